// File: rtl/mdu_sched.sv
// mdu_sched: multiply/divide scheduler beside the E-stage ALU.
// Owns HI/LO, computes MULT/MULTU/DIV/DIVU results at issue and commits them
// after a fixed busy latency; handles MTHI/MTLO; raises the D-stage stall for
// MDU-class instructions that would collide with an in-flight operation.
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_start     E-stage issue strobe, qualifies i_md_op
//   i_md_op     1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 0/7 no-op
//   i_a, i_b    forwarded rs / rt operands
//   i_d_is_md   D-stage instruction is MDU-class
//   o_busy      multi-cycle operation in flight
//   o_stall_c   combinational stall request to PC/D/E-clear logic
//   o_hi, o_lo  HI / LO registers
module mdu_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [2:0]  i_md_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_d_is_md,
    output logic        o_busy,
    output logic        o_stall_c,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_p_hi;
    logic [31:0]        r_p_lo;
    logic               r_dz;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_is_long_op;
    logic               w_is_div;
    logic               w_b_zero;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [63:0]        w_sprod;
    logic [63:0]        w_uprod;
    logic [31:0]        w_a_mag;
    logic [31:0]        w_b_mag;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;
    logic [31:0]        w_sq_mag;
    logic [31:0]        w_sr_mag;
    logic [31:0]        w_sq;
    logic [31:0]        w_sr;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;

    // Op decode
    assign w_is_long_op = (i_md_op >= OP_MULT) && (i_md_op <= OP_DIVU);
    assign w_is_div     = (i_md_op == OP_DIV) || (i_md_op == OP_DIVU);
    assign w_b_zero     = (i_b == 32'd0);
    assign w_a_neg      = i_a[31];
    assign w_b_neg      = i_b[31];

    // Signed product via explicit sign extension keeps all arithmetic unsigned
    assign w_sprod = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide on magnitudes: avoids the INT_MIN/-1 overflow case and
    // yields truncation toward zero with remainder signed like the dividend
    assign w_a_mag  = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_b_mag  = w_b_neg ? (32'd0 - i_b) : i_b;
    assign w_uq     = w_b_zero ? 32'd0 : (i_a / i_b);
    assign w_ur     = w_b_zero ? 32'd0 : (i_a % i_b);
    assign w_sq_mag = w_b_zero ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_sr_mag = w_b_zero ? 32'd0 : (w_a_mag % w_b_mag);
    assign w_sq     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr     = w_a_neg ? (32'd0 - w_sr_mag) : w_sr_mag;

    // Result select for the pending HI/LO pair
    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (i_md_op)
            OP_MULT: begin
                w_res_hi = w_sprod[63:32];
                w_res_lo = w_sprod[31:0];
            end
            OP_MULTU: begin
                w_res_hi = w_uprod[63:32];
                w_res_lo = w_uprod[31:0];
            end
            OP_DIV: begin
                w_res_hi = w_sr;
                w_res_lo = w_sq;
            end
            OP_DIVU: begin
                w_res_hi = w_ur;
                w_res_lo = w_uq;
            end
            default: begin
                w_res_hi = 32'd0;
                w_res_lo = 32'd0;
            end
        endcase
    end

    // Scheduler FSM, busy counter and HI/LO ownership
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_p_hi  <= 32'd0;
            r_p_lo  <= 32'd0;
            r_dz    <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (w_is_long_op) begin
                            r_p_hi  <= w_res_hi;
                            r_p_lo  <= w_res_lo;
                            r_dz    <= w_is_div && w_b_zero;
                            r_cnt   <= w_is_div ? CNT_W'(DIV_CYCLES)
                                                : CNT_W'(MULT_CYCLES);
                            r_state <= S_BUSY;
                        end else if (i_md_op == OP_MTHI) begin
                            r_hi <= i_a;
                        end else if (i_md_op == OP_MTLO) begin
                            r_lo <= i_a;
                        end
                    end
                end
                S_BUSY: begin
                    // Issues arriving here are dropped; stall prevents them
                    if (r_cnt == CNT_W'(1)) begin
                        if (!r_dz) begin
                            r_hi <= r_p_hi;
                            r_lo <= r_p_lo;
                        end
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy    = (r_state == S_BUSY);
    assign o_hi      = r_hi;
    assign o_lo      = r_lo;

    // Covers the issue cycle as well as the in-flight cycles; held low in reset
    assign o_stall_c = i_rst_n & i_d_is_md & (o_busy | (i_start & w_is_long_op));

endmodule

// File: tb/tb_mdu_sched.sv
// Testbench for mdu_sched: directed scenarios plus randomized traffic, checked
// every cycle against a timeline-based reference model of HI/LO, busy and stall.
module tb_mdu_sched;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_is_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_sched #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_md_op   (md_op),
        .i_a       (a),
        .i_b       (b),
        .i_d_is_md (d_is_md),
        .o_busy    (busy),
        .o_stall_c (stall),
        .o_hi      (hi),
        .o_lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: absolute cycle numbers instead of a counter
    int          cyc     = 0;
    int          m_done  = 0;    // first cycle after the in-flight op (busy while cyc < m_done)
    bit          m_pend  = 0;
    bit          m_dz    = 0;
    logic [31:0] m_hi    = 32'd0;
    logic [31:0] m_lo    = 32'd0;
    logic [31:0] m_p_hi  = 32'd0;
    logic [31:0] m_p_lo  = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit is_long(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    // Arithmetic result of an MDU op computed with 64-bit integer math
    task automatic model_result(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] rh, output logic [31:0] rl, output bit dz);
        longint          sx, sy, sp, sq, sr;
        longint unsigned ux, uy, up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x) & 64'hFFFF_FFFF;
        uy = longint'(y) & 64'hFFFF_FFFF;
        rh = 32'd0;
        rl = 32'd0;
        dz = 0;
        case (op)
            3'd1: begin sp = sx * sy; rh = sp[63:32]; rl = sp[31:0]; end
            3'd2: begin up = ux * uy; rh = up[63:32]; rl = up[31:0]; end
            3'd3: begin
                if (y == 32'd0) dz = 1;
                else begin sq = sx / sy; sr = sx % sy; rh = sr[31:0]; rl = sq[31:0]; end
            end
            3'd4: begin
                if (y == 32'd0) dz = 1;
                else begin rh = x % y; rl = x / y; end
            end
            default: ;
        endcase
    endtask

    // One clock cycle: drive, check mid-cycle against the model, advance the model
    task automatic tick(input logic st, input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic d);
        bit m_busy;
        start   = st;
        md_op   = op;
        a       = x;
        b       = y;
        d_is_md = d;
        @(negedge clk);
        m_busy = (cyc < m_done);
        check_eq("busy",  {31'd0, busy},  {31'd0, m_busy});
        check_eq("stall", {31'd0, stall}, {31'd0, (d & (m_busy | (st & is_long(op))))});
        check_eq("hi", hi, m_hi);
        check_eq("lo", lo, m_lo);
        @(posedge clk);
        if (m_pend && (cyc + 1 == m_done)) begin
            if (!m_dz) begin
                m_hi = m_p_hi;
                m_lo = m_p_lo;
            end
            m_pend = 0;
        end
        if (st && !m_busy) begin
            if (is_long(op)) begin
                model_result(op, x, y, m_p_hi, m_p_lo, m_dz);
                m_pend = 1;
                m_done = cyc + 1 + ((op >= 3'd3) ? int'(DIV_N) : int'(MULT_N));
            end else if (op == 3'd5) begin
                m_hi = x;
            end else if (op == 3'd6) begin
                m_lo = x;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n, input logic d);
        for (int i = 0; i < n; i++) tick(1'b0, 3'd0, $urandom, $urandom, d);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] special [5];
        special[0] = 32'h0000_0000;
        special[1] = 32'hFFFF_FFFF;
        special[2] = 32'h8000_0000;
        special[3] = 32'h7FFF_FFFF;
        special[4] = 32'h0000_0001;
        if ($urandom_range(0, 3) == 0) return special[$urandom_range(0, 4)];
        if ($urandom_range(0, 2) == 0) return 32'($signed($urandom_range(0, 40)) - 20);
        return $urandom;
    endfunction

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        md_op   = 3'd0;
        a       = 32'd0;
        b       = 32'd0;
        d_is_md = 1'b1;
        #2;
        check_eq("rst_busy",  {31'd0, busy},  32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // MULT -2 * 3
        tick(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(MULT_N + 1, 1'b0);
        check_eq("mult_hi", hi, 32'hFFFF_FFFF);
        check_eq("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU max * max
        tick(1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        idle(MULT_N + 1, 1'b0);
        check_eq("multu_hi", hi, 32'hFFFF_FFFE);
        check_eq("multu_lo", lo, 32'h0000_0001);

        // DIV -7 / 2 with D-stage MDU instruction waiting
        tick(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
        idle(DIV_N + 1, 1'b1);
        check_eq("div_hi", hi, 32'hFFFF_FFFF);
        check_eq("div_lo", lo, 32'hFFFF_FFFD);

        // DIV INT_MIN / -1
        tick(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        idle(DIV_N + 1, 1'b1);
        check_eq("divovf_hi", hi, 32'h0000_0000);
        check_eq("divovf_lo", lo, 32'h8000_0000);

        // MTHI, then DIVU by zero leaves HI/LO untouched
        tick(1'b1, 3'd5, 32'h1234_5678, 32'd0, 1'b0);
        check_eq("mthi_hi", hi, 32'h1234_5678);
        tick(1'b1, 3'd4, 32'd5, 32'd0, 1'b0);
        idle(DIV_N + 1, 1'b0);
        check_eq("divz_hi", hi, 32'h1234_5678);
        check_eq("divz_lo", lo, 32'h8000_0000);

        // MTLO path
        tick(1'b1, 3'd6, 32'hCAFE_F00D, 32'd0, 1'b0);
        check_eq("mtlo_lo", lo, 32'hCAFE_F00D);

        // DIV issued at busy cycle 2 of a MULT is dropped
        tick(1'b1, 3'd1, 32'd7, 32'd9, 1'b0);
        idle(1, 1'b0);
        tick(1'b1, 3'd3, 32'd100, 32'd3, 1'b1);
        idle(MULT_N, 1'b0);
        check_eq("ign_hi", hi, 32'd0);
        check_eq("ign_lo", lo, 32'd63);
        check_eq("ign_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a DIV aborts it
        tick(1'b1, 3'd3, 32'd1000, 32'd7, 1'b0);
        idle(3, 1'b0);
        start   = 1'b1;
        md_op   = 3'd3;
        d_is_md = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mrst_busy",  {31'd0, busy},  32'd0);
        check_eq("mrst_stall", {31'd0, stall}, 32'd0);
        check_eq("mrst_hi", hi, 32'd0);
        check_eq("mrst_lo", lo, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0; m_pend = 0; m_done = 0;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        start = 1'b0;
        idle(DIV_N + 4, 1'b0);
        check_eq("post_rst_hi", hi, 32'd0);
        check_eq("post_rst_lo", lo, 32'd0);

        // Randomized traffic, including issues attempted while busy
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                 rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
        end
        idle(DIV_N + 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mdu_sched.md
# mdu_sched

Multiply/divide scheduler for the five-stage pipeline: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issues from stage E, owns the HI/LO registers, and models the multi-cycle unit latency with a busy counter. It generates the D-stage stall for any MDU-class instruction (MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO) that would collide with an in-flight operation. It sits beside the ALU in stage E and ORs its stall into the existing hazard stall.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be ≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be ≥1)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  E-stage issue strobe; qualifies md_op, one cycle per instruction
- md_op  input  3  1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 0 and 7 are no-ops
- a  input  32  forwarded rs value from stage E
- b  input  32  forwarded rt value from stage E
- d_is_md  input  1  instruction in stage D is MDU-class
- busy  output  1  multi-cycle operation in flight
- stall  output  1  stall request to PC/D/E-clear logic
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- States: IDLE, BUSY. A 4-bit down-counter `cnt` and 64-bit pending result {p_hi, p_lo} are held.
- IDLE, start with md_op in 1..4: compute the result from a and b, latch it into p_hi/p_lo, load cnt with MULT_CYCLES or DIV_CYCLES, and go to BUSY.
  - MULT: signed 64-bit product; HI=[63:32], LO=[31:0].
  - MULTU: unsigned 64-bit product; HI=[63:32], LO=[31:0].
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend. 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (b==0): full busy duration runs; HI/LO are left unchanged at completion.
- IDLE, start with md_op 5 or 6: hi<=a or lo<=a at that edge; no busy; state stays IDLE.
- BUSY: cnt decrements every cycle. When cnt==1, the edge writes hi<=p_hi and lo<=p_lo (unless div-by-zero), clears cnt, and returns to IDLE.
- start while BUSY: ignored entirely, with no state or HI/LO change. The pipeline must never do this; stall guarantees it.
- md_op 0 or 7 with start: no effect.
- busy = (state==BUSY).
- stall = d_is_md & (busy | (start & md_op in 1..4)). This is combinational and covers both the issue cycle and the in-flight cycles.
- Reset (asserted low, asynchronously): state=IDLE, cnt=0, hi=0, lo=0, p_hi=p_lo=0, busy=0. stall=0 while reset is asserted. Reset during BUSY aborts the operation with no HI/LO write.

## Timing
- Issue at cycle t (start high): busy is high in cycles t+1..t+N (N = MULT_CYCLES or DIV_CYCLES). The new hi/lo is visible from cycle t+N+1, the same cycle busy is first low.
- A back-to-back issue is accepted at cycle t+N+1 at the earliest.
- MTHI/MTLO at cycle t: the value is visible at t+1.
- MFHI/MFLO read hi/lo combinationally at the consumer. A D-stage MFHI is stalled through t..t+N and reads the new value once it advances.
- Operands are sampled only at the issue edge. Changes to a and b during BUSY have no effect.

## Test plan
- Reset, then MULT a=0xFFFFFFFE(-2), b=3 with MULT_CYCLES=5. Required: busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF. Required: hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- DIV a=-7, b=2, with d_is_md held high throughout. Required: stall high at issue and for all 10 busy cycles, low after; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Repeat with a=0x80000000, b=-1: lo=0x80000000, hi=0.
- MTHI a=0x12345678, then DIVU a=5, b=0. Required: hi=0x12345678 one cycle after MTHI; after 10 busy cycles, hi and lo are unchanged.
- Issue MULT, then pulse start with DIV at busy cycle 2. Required: the DIV is ignored and the MULT result is written at the original time. Then assert reset mid-BUSY of a new DIV: busy=0 and hi=lo=0 immediately, and no write occurs after reset is released.
